// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: tracks EX/MEM/WB destination tags, selects bypass sources,
// raises load-use / no-bypass stalls and branch flushes, and counts both events.
module pipe_hazard_unit #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NREG     = 32,
   parameter int unsigned ZERO_REG = 31,
   parameter int unsigned BR_STAGE = 2,
   parameter int unsigned FWD_EN   = 1,
   localparam int unsigned RW      = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            id_valid,
   input  logic [RW-1:0]   id_rs1,
   input  logic [RW-1:0]   id_rs2,
   input  logic            id_rs1_used,
   input  logic            id_rs2_used,
   input  logic [RW-1:0]   id_rd,
   input  logic            id_regwrite,
   input  logic            id_memread,
   input  logic [XLEN-1:0] id_rf1,
   input  logic [XLEN-1:0] id_rf2,
   input  logic [XLEN-1:0] ex_result,
   input  logic [XLEN-1:0] mem_alures,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic [XLEN-1:0] wb_data,
   input  logic            br_taken,
   output logic [XLEN-1:0] op1,
   output logic [XLEN-1:0] op2,
   output logic [1:0]      fwd_sel1,
   output logic [1:0]      fwd_sel2,
   output logic            stall,
   output logic            bubble,
   output logic            flush,
   output logic [31:0]     stall_cnt,
   output logic [31:0]     flush_cnt
);

   localparam logic [RW-1:0] ZERO_IDX = RW'(ZERO_REG);

   typedef struct packed {
      logic          v;
      logic [RW-1:0] rd;
      logic          rw;
      logic          mr;
   } tag_t;

   typedef enum logic {RUN, HOLD} state_t;

   tag_t        ex_q, mem_q, wb_q, ex_d, mem_d, wb_d;
   state_t      state_q, state_d;
   logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic        e1, m1, w1, e2, m2, w2, hz;
   logic [XLEN-1:0] mem_fwd;

   function automatic logic hit(input tag_t t, input logic [RW-1:0] s, input logic used);
      return t.v && t.rw && (t.rd == s) && (s != ZERO_IDX) && used;
   endfunction

   // Youngest match wins; without full bypass EX/MEM matches stall instead of forwarding.
   function automatic logic [1:0] pick(input logic e, input logic m, input logic w);
      if (e) return (FWD_EN != 0) ? 2'd1 : 2'd0;
      if (m) return (FWD_EN != 0) ? 2'd2 : 2'd0;
      if (w) return 2'd3;
      return 2'd0;
   endfunction

   always_comb begin
      e1 = hit(ex_q,  id_rs1, id_rs1_used);
      m1 = hit(mem_q, id_rs1, id_rs1_used);
      w1 = hit(wb_q,  id_rs1, id_rs1_used);
      e2 = hit(ex_q,  id_rs2, id_rs2_used);
      m2 = hit(mem_q, id_rs2, id_rs2_used);
      w2 = hit(wb_q,  id_rs2, id_rs2_used);
      hz = id_valid & (((e1 | e2) & ex_q.mr) | ((FWD_EN == 0) & (e1 | m1 | e2 | m2)));

      flush    = br_taken & ~clr;
      stall    = hz & ~flush & ~clr;
      bubble   = (hz | flush) & ~clr;
      fwd_sel1 = clr ? 2'd0 : pick(e1, m1, w1);
      fwd_sel2 = clr ? 2'd0 : pick(e2, m2, w2);

      mem_fwd = mem_q.mr ? mem_rdata : mem_alures;
      case (fwd_sel1)
         2'd1:    op1 = ex_result;
         2'd2:    op1 = mem_fwd;
         2'd3:    op1 = wb_data;
         default: op1 = id_rf1;
      endcase
      case (fwd_sel2)
         2'd1:    op2 = ex_result;
         2'd2:    op2 = mem_fwd;
         2'd3:    op2 = wb_data;
         default: op2 = id_rf2;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (stall)  state_d = HOLD;
         HOLD:    if (!stall) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // A taken branch in MEM also kills the instruction currently in EX.
   always_comb begin
      ex_d.v  = id_valid & ~bubble;
      ex_d.rd = id_rd;
      ex_d.rw = id_regwrite;
      ex_d.mr = id_memread;
      mem_d   = ex_q;
      if (flush && (BR_STAGE == 2)) mem_d.v = 1'b0;
      wb_d    = mem_q;
      stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
      flush_cnt_d = (flush && (flush_cnt_q != '1)) ? flush_cnt_q + 32'd1 : flush_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         state_q     <= RUN;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: a full-bypass/MEM-branch instance and a WB-only/EX-branch
// instance share stimulus; directed scenarios then random traffic against an in-flight model.
module tb_pipe_hazard_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        clr, id_valid, id_rs1_used, id_rs2_used, id_regwrite, id_memread, br_taken;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [31:0] id_rf1, id_rf2, ex_result, mem_alures, mem_rdata, wb_data;

   logic [31:0] a_op1, a_op2, a_sc, a_fc, b_op1, b_op2, b_sc, b_fc;
   logic [1:0]  a_s1, a_s2, b_s1, b_s2;
   logic        a_st, a_bb, a_fl, b_st, b_bb, b_fl;

   pipe_hazard_unit #(.XLEN(32), .NREG(32), .ZERO_REG(31), .BR_STAGE(2), .FWD_EN(1)) u_a (
      .clk(clk), .clr(clr), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .id_rf1(id_rf1), .id_rf2(id_rf2),
      .ex_result(ex_result), .mem_alures(mem_alures), .mem_rdata(mem_rdata), .wb_data(wb_data),
      .br_taken(br_taken), .op1(a_op1), .op2(a_op2), .fwd_sel1(a_s1), .fwd_sel2(a_s2),
      .stall(a_st), .bubble(a_bb), .flush(a_fl), .stall_cnt(a_sc), .flush_cnt(a_fc));

   pipe_hazard_unit #(.XLEN(32), .NREG(32), .ZERO_REG(31), .BR_STAGE(1), .FWD_EN(0)) u_b (
      .clk(clk), .clr(clr), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .id_rf1(id_rf1), .id_rf2(id_rf2),
      .ex_result(ex_result), .mem_alures(mem_alures), .mem_rdata(mem_rdata), .wb_data(wb_data),
      .br_taken(br_taken), .op1(b_op1), .op2(b_op2), .fwd_sel1(b_s1), .fwd_sel2(b_s2),
      .stall(b_st), .bubble(b_bb), .flush(b_fl), .stall_cnt(b_sc), .flush_cnt(b_fc));

   typedef struct {
      bit          v;
      int unsigned rd;
      bit          rw;
      bit          mr;
   } mtag_t;

   // pipe[k][0..2] = instructions in EX, MEM, WB for instance k
   mtag_t       pipe [2][3];
   int unsigned scnt [2];
   int unsigned fcnt [2];
   bit          FWD  [2] = '{1'b1, 1'b0};
   int          BRS  [2] = '{2, 1};
   int          n_assert = 0;
   int          n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int youngest(input int k, input int unsigned s, input bit used);
      if (!used || s == 31) return -1;
      for (int i = 0; i < 3; i++)
         if (pipe[k][i].v && pipe[k][i].rw && pipe[k][i].rd == s) return i;
      return -1;
   endfunction

   function automatic logic [1:0] sel_of(input int k, input int y);
      if (y < 0) return 2'd0;
      if (FWD[k] || y == 2) return 2'(y + 1);
      return 2'd0;
   endfunction

   function automatic logic [31:0] val_of(input int k, input logic [1:0] s, input logic [31:0] rf);
      case (s)
         2'd1:    return ex_result;
         2'd2:    return pipe[k][1].mr ? mem_rdata : mem_alures;
         2'd3:    return wb_data;
         default: return rf;
      endcase
   endfunction

   task automatic model_expect(input int k, output logic [1:0] s1, output logic [1:0] s2,
                               output logic [31:0] o1, output logic [31:0] o2,
                               output logic st, output logic bb, output logic fl);
      int  y1, y2;
      bit  haz;
      y1 = youngest(k, int'(id_rs1), id_rs1_used);
      y2 = youngest(k, int'(id_rs2), id_rs2_used);
      haz = 1'b0;
      foreach (pipe[k][i]) begin
         if ((y1 == i || y2 == i) && (FWD[k] ? (i == 0 && pipe[k][0].mr) : (i < 2))) haz = 1'b1;
      end
      haz = haz && id_valid;
      if (clr) begin
         s1 = 2'd0; s2 = 2'd0; st = 1'b0; bb = 1'b0; fl = 1'b0;
      end else begin
         s1 = sel_of(k, y1); s2 = sel_of(k, y2);
         fl = br_taken; st = haz && !fl; bb = haz || fl;
      end
      o1 = val_of(k, s1, id_rf1);
      o2 = val_of(k, s2, id_rf2);
   endtask

   task automatic model_advance(input int k);
      logic [1:0] s1, s2; logic [31:0] o1, o2; logic st, bb, fl;
      model_expect(k, s1, s2, o1, o2, st, bb, fl);
      if (clr) begin
         foreach (pipe[k][i]) pipe[k][i].v = 1'b0;
         scnt[k] = 0; fcnt[k] = 0;
      end else begin
         if (st) scnt[k]++;
         if (fl) fcnt[k]++;
         pipe[k][2] = pipe[k][1];
         pipe[k][1] = pipe[k][0];
         if (fl && BRS[k] == 2) pipe[k][1].v = 1'b0;
         pipe[k][0] = '{v: id_valid && !bb, rd: int'(id_rd), rw: id_regwrite, mr: id_memread};
      end
   endtask

   task automatic cmp_inst(input string n, input int k, input logic [1:0] s1, input logic [1:0] s2,
                           input logic [31:0] o1, input logic [31:0] o2, input logic st,
                           input logic bb, input logic fl, input logic [31:0] sc, input logic [31:0] fc);
      logic [1:0] e1, e2; logic [31:0] eo1, eo2; logic est, ebb, efl;
      model_expect(k, e1, e2, eo1, eo2, est, ebb, efl);
      chk({n, ".sel1"}, 32'(s1), 32'(e1));
      chk({n, ".sel2"}, 32'(s2), 32'(e2));
      chk({n, ".op1"}, o1, eo1);
      chk({n, ".op2"}, o2, eo2);
      chk({n, ".stall"}, 32'(st), 32'(est));
      chk({n, ".bubble"}, 32'(bb), 32'(ebb));
      chk({n, ".flush"}, 32'(fl), 32'(efl));
      chk({n, ".stall_cnt"}, sc, scnt[k]);
      chk({n, ".flush_cnt"}, fc, fcnt[k]);
   endtask

   task automatic tick();
      #1;
      cmp_inst("a", 0, a_s1, a_s2, a_op1, a_op2, a_st, a_bb, a_fl, a_sc, a_fc);
      cmp_inst("b", 1, b_s1, b_s2, b_op1, b_op2, b_st, b_bb, b_fl, b_sc, b_fc);
      @(posedge clk);
      model_advance(0);
      model_advance(1);
      @(negedge clk);
   endtask

   task automatic instr(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                        input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
      id_valid = v; id_rd = rd; id_regwrite = rw; id_memread = mr;
      id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
   endtask

   task automatic do_reset();
      clr = 1'b1; instr(0, 0, 0, 0, 0, 0, 0, 0); br_taken = 1'b0;
      tick();
      clr = 1'b0;
   endtask

   function automatic logic [4:0] rnd_reg();
      int unsigned r;
      r = $urandom_range(0, 9);
      return (r >= 8) ? 5'd31 : 5'(r);
   endfunction

   initial begin
      clr = 1'b1; br_taken = 1'b0;
      instr(0, 0, 0, 0, 0, 0, 0, 0);
      id_rf1 = 32'h1111; id_rf2 = 32'h2222; ex_result = 32'h0; mem_alures = 32'h0;
      mem_rdata = 32'h0; wb_data = 32'h0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         foreach (pipe[k][i]) pipe[k][i] = '{v: 1'b0, rd: 0, rw: 1'b0, mr: 1'b0};
         scnt[k] = 0; fcnt[k] = 0;
      end
      #1;
      chk("reset.stall", 32'(a_st), 32'd0);
      chk("reset.sel1", 32'(a_s1), 32'd0);
      chk("reset.stall_cnt", a_sc, 32'd0);
      tick();
      clr = 1'b0;

      // ADD x1 in EX forwards to rs1
      instr(1, 1, 1, 0, 0, 0, 0, 0); tick();
      instr(1, 10, 1, 0, 1, 1, 0, 0); ex_result = 32'h15;
      #1;
      chk("ex_fwd.sel1", 32'(a_s1), 32'd1);
      chk("ex_fwd.op1", a_op1, 32'h15);
      chk("ex_fwd.stall", 32'(a_st), 32'd0);
      tick();

      // x2 in EX and MEM: youngest wins on both sources
      instr(1, 2, 1, 0, 0, 0, 0, 0); tick();
      instr(1, 2, 1, 0, 0, 0, 0, 0); tick();
      instr(1, 11, 0, 0, 2, 1, 2, 1); ex_result = 32'hAA; mem_alures = 32'hBB;
      #1;
      chk("young.sel1", 32'(a_s1), 32'd1);
      chk("young.op1", a_op1, 32'hAA);
      chk("young.op2", a_op2, 32'hAA);
      tick();

      // load-use: one stall cycle, then MEM load data forwards
      do_reset();
      instr(1, 3, 1, 1, 0, 0, 0, 0); tick();
      instr(1, 9, 0, 0, 3, 1, 0, 0); mem_rdata = 32'h1234;
      #1;
      chk("lu.stall", 32'(a_st), 32'd1);
      chk("lu.bubble", 32'(a_bb), 32'd1);
      tick();
      #1;
      chk("lu.stall_cnt", a_sc, 32'd1);
      chk("lu.sel1", 32'(a_s1), 32'd2);
      chk("lu.op1", a_op1, 32'h1234);
      chk("lu.stall_after", 32'(a_st), 32'd0);
      tick();

      // no full bypass: stall until the producer reaches WB
      do_reset();
      instr(1, 4, 1, 0, 0, 0, 0, 0); tick();
      instr(1, 12, 0, 0, 4, 1, 0, 0); wb_data = 32'hCAFE;
      #1; chk("nofwd.stall0", 32'(b_st), 32'd1); tick();
      #1; chk("nofwd.stall1", 32'(b_st), 32'd1); tick();
      #1;
      chk("nofwd.stall2", 32'(b_st), 32'd0);
      chk("nofwd.sel1", 32'(b_s1), 32'd3);
      chk("nofwd.op1", b_op1, 32'hCAFE);
      chk("nofwd.stall_cnt", b_sc, 32'd2);
      tick();

      // branch taken during pending load-use: flush wins, EX and MEM are bubbles after
      do_reset();
      instr(1, 5, 1, 1, 0, 0, 0, 0); tick();
      instr(1, 13, 0, 0, 5, 1, 0, 0); br_taken = 1'b1;
      #1;
      chk("flush.flush", 32'(a_fl), 32'd1);
      chk("flush.stall", 32'(a_st), 32'd0);
      chk("flush.bubble", 32'(a_bb), 32'd1);
      tick();
      br_taken = 1'b0;
      #1;
      chk("flush.flush_cnt", a_fc, 32'd1);
      chk("flush.sel1_after", 32'(a_s1), 32'd0);
      chk("flush.stall_after", 32'(a_st), 32'd0);
      chk("flush.stall_cnt", a_sc, 32'd0);
      tick();

      // hard-zero register never forwards; reset mid-stall
      instr(1, 31, 1, 0, 0, 0, 0, 0); tick();
      instr(1, 14, 0, 0, 31, 1, 0, 0); id_rf1 = 32'h77;
      #1;
      chk("zero.sel1", 32'(a_s1), 32'd0);
      chk("zero.op1", a_op1, 32'h77);
      chk("zero.stall", 32'(a_st), 32'd0);
      tick();
      instr(1, 6, 1, 1, 0, 0, 0, 0); tick();
      instr(1, 15, 0, 0, 6, 1, 0, 0);
      #1;
      chk("rst_mid.stall_a", 32'(a_st), 32'd1);
      chk("rst_mid.stall_b", 32'(b_st), 32'd1);
      tick();
      clr = 1'b1;
      #1; chk("rst_mid.stall_during", 32'(b_st), 32'd0);
      tick();
      clr = 1'b0;
      #1;
      chk("rst_mid.stall_cnt_a", a_sc, 32'd0);
      chk("rst_mid.stall_cnt_b", b_sc, 32'd0);
      chk("rst_mid.stall_b_after", 32'(b_st), 32'd0);
      tick();

      // random traffic against the in-flight model
      for (int n = 0; n < 800; n++) begin
         clr         = ($urandom_range(0, 59) == 0);
         id_valid    = ($urandom_range(0, 3) != 0);
         id_rd       = rnd_reg();
         id_rs1      = rnd_reg();
         id_rs2      = rnd_reg();
         id_rs1_used = ($urandom_range(0, 3) != 0);
         id_rs2_used = ($urandom_range(0, 1) != 0);
         id_memread  = ($urandom_range(0, 3) == 0);
         id_regwrite = id_memread || ($urandom_range(0, 3) != 0);
         br_taken    = ($urandom_range(0, 9) == 0);
         id_rf1 = $urandom; id_rf2 = $urandom; ex_result = $urandom;
         mem_alures = $urandom; mem_rdata = $urandom; wb_data = $urandom;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
